// File: rtl/mem_stage.sv
// ============================================================================
// Module      : mem_stage
// Description : Pipeline memory stage. Non-memory results pass straight
//               through in one cycle; loads/stores issue a single aligned
//               dword request, wait for mem_ack (bounded by TIMEOUT) and
//               return a lane-extracted, extended load value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EXMEM_ready,
    input  logic [63:0] exmm_aluresult,
    input  logic [5:0]  dest_reg,
    input  logic        mem_active,
    input  logic        load,
    input  logic [1:0]  mem_size,
    input  logic        load_unsigned,
    input  logic [63:0] store_data,
    output logic        MEMEX_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wstrb,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic [5:0]  MEMEX_rd,
    output logic [63:0] MEMEX_rdval,
    output logic        MEMWB_ready,
    output logic        mem_err
);

    // Counter only has to hold 0..TIMEOUT-1 (the cycle index inside ACCESS).
    localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [63:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        load_q, load_d;
    logic [5:0]  rd_q, rd_d;
    logic [63:0] sdata_q, sdata_d;
    logic [5:0]  out_rd_q, out_rd_d;
    logic [63:0] out_val_q, out_val_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic        w_misaligned;
    logic        w_in_access;
    logic [7:0]  w_strb_base;
    logic [63:0] w_lane;
    logic [63:0] w_load_val;

    // Alignment of the incoming effective address against its access size.
    always_comb begin
        w_misaligned = 1'b0;
        case (mem_size)
            2'd1:    w_misaligned = exmm_aluresult[0];
            2'd2:    w_misaligned = (exmm_aluresult[1:0] != 2'd0);
            2'd3:    w_misaligned = (exmm_aluresult[2:0] != 3'd0);
            default: w_misaligned = 1'b0;
        endcase
    end

    // Memory-side outputs come from the captured registers and are zero outside ACCESS.
    always_comb begin
        w_in_access = (state_q == S_ACCESS);
        case (size_q)
            2'd0:    w_strb_base = 8'h01;
            2'd1:    w_strb_base = 8'h03;
            2'd2:    w_strb_base = 8'h0F;
            default: w_strb_base = 8'hFF;
        endcase
        mem_req     = w_in_access;
        mem_we      = w_in_access & ~load_q;
        mem_addr    = w_in_access ? {addr_q[63:3], 3'b000} : 64'd0;
        mem_wstrb   = w_in_access ? (w_strb_base << addr_q[2:0]) : 8'd0;
        mem_wdata   = w_in_access ? (sdata_q << {addr_q[2:0], 3'b000}) : 64'd0;
        // Reset is folded in so the stall is also low while reset is held.
        MEMEX_stall = reset & (w_in_access |
                      ((state_q == S_IDLE) & EXMEM_ready & mem_active & ~w_misaligned));
    end

    // Extract the addressed lane of the read dword and extend it.
    always_comb begin
        w_lane = mem_rdata >> {addr_q[2:0], 3'b000};
        case (size_q)
            2'd0:    w_load_val = uns_q ? {56'd0, w_lane[7:0]}  : {{56{w_lane[7]}},  w_lane[7:0]};
            2'd1:    w_load_val = uns_q ? {48'd0, w_lane[15:0]} : {{48{w_lane[15]}}, w_lane[15:0]};
            2'd2:    w_load_val = uns_q ? {32'd0, w_lane[31:0]} : {{32{w_lane[31]}}, w_lane[31:0]};
            default: w_load_val = w_lane;
        endcase
    end

    // Next-state and completion logic for the IDLE/ACCESS machine.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        size_d    = size_q;
        uns_d     = uns_q;
        load_d    = load_q;
        rd_d      = rd_q;
        sdata_d   = sdata_q;
        out_rd_d  = out_rd_q;
        out_val_d = out_val_q;
        ready_d   = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (EXMEM_ready) begin
                    if (!mem_active) begin
                        ready_d   = 1'b1;
                        out_rd_d  = dest_reg;
                        out_val_d = exmm_aluresult;
                    end else if (w_misaligned) begin
                        ready_d   = 1'b1;
                        err_d     = 1'b1;
                        out_rd_d  = 6'd0;
                        out_val_d = 64'd0;
                    end else begin
                        addr_d  = exmm_aluresult;
                        size_d  = mem_size;
                        uns_d   = load_unsigned;
                        load_d  = load;
                        rd_d    = dest_reg;
                        sdata_d = store_data;
                        cnt_d   = '0;
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ack) begin
                    // An ack on the final allowed cycle still completes normally.
                    state_d   = S_IDLE;
                    ready_d   = 1'b1;
                    out_rd_d  = load_q ? rd_q : 6'd0;
                    out_val_d = load_q ? w_load_val : 64'd0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    ready_d   = 1'b1;
                    err_d     = 1'b1;
                    out_rd_d  = 6'd0;
                    out_val_d = 64'd0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // x0 must never be forwarded with a nonzero value.
        if (out_rd_d == 6'd0) begin
            out_val_d = 64'd0;
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= 64'd0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            load_q    <= 1'b0;
            rd_q      <= 6'd0;
            sdata_q   <= 64'd0;
            out_rd_q  <= 6'd0;
            out_val_q <= 64'd0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            load_q    <= load_d;
            rd_q      <= rd_d;
            sdata_q   <= sdata_d;
            out_rd_q  <= out_rd_d;
            out_val_q <= out_val_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign MEMEX_rd    = out_rd_q;
    assign MEMEX_rdval = out_val_q;
    assign MEMWB_ready = ready_q;
    assign mem_err     = err_q;

endmodule

`default_nettype wire
